a2_bridge_responder: RTL and testbench

- Synthesizable bus-functional model of the Apple II side of the A2Bridge. It is the responder to the bridge-mux initiator inside apple_bus.
- Generates a2_phi1 and a2_7M, and replays host-queued CPU bus cycles through a small FIFO.
- Answers bridge sel/rd_n/wr_n strobes with address, data and control bytes.
- Captures bytes a card drives during CPU read cycles.
- Used for board-to-board loopback and as the standard bench driver for apple_bus.

---
 rtl/a2_bridge_responder.sv | 190 +++++++++++++++++++
 tb/tb_a2_bridge_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2_bridge_responder.sv
// rtl/a2_bridge_responder.sv - Apple II side responder for the A2Bridge: phi1/7M generation, queued CPU cycle replay, bridge strobe answers
module a2_bridge_responder #(
    parameter int PHI_HALF   = 27,
    parameter int M7_HALF    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc_valid_i,
    output logic        cyc_ready_o,
    input  logic [15:0] cyc_addr_i,
    input  logic [7:0]  cyc_data_i,
    input  logic        cyc_rw_n_i,
    output logic        a2_phi1_o,
    output logic        a2_7M_o,
    input  logic [2:0]  bridge_sel_i,
    input  logic        bridge_rd_n_i,
    input  logic        bridge_wr_n_i,
    input  logic [7:0]  bridge_d_i,
    output logic [7:0]  bridge_d_o,
    output logic        bridge_d_oe_o,
    output logic [7:0]  card_data_o,
    output logic        card_data_valid_o,
    output logic        idle_o,
    output logic        error_o
);
    localparam int PW = (PHI_HALF > 1) ? $clog2(PHI_HALF) : 1;
    localparam int MW = (M7_HALF > 1) ? $clog2(M7_HALF) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] PHI_LAST  = PW'(PHI_HALF - 1);
    localparam logic [MW-1:0] M7_LAST   = MW'(M7_HALF - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    logic [PW-1:0] phi_cnt, phi_cnt_nx;
    logic [MW-1:0] m7_cnt;
    logic          phi1_nx, phi0_nx, phi_wrap, pop_evt, pop_soon;

    // pop_soon looks one clk ahead so a full FIFO can still take a push on the pop edge
    always_comb begin
        phi_wrap   = (phi_cnt == PHI_LAST);
        phi_cnt_nx = phi_wrap ? '0 : phi_cnt + 1'b1;
        phi1_nx    = phi_wrap ? ~a2_phi1_o : a2_phi1_o;
        phi0_nx    = ~phi1_nx;
        pop_evt    = phi_wrap && !a2_phi1_o;
        pop_soon   = (phi_cnt_nx == PHI_LAST) && !phi1_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi_cnt   <= '0;
            a2_phi1_o <= 1'b1;
            m7_cnt    <= '0;
            a2_7M_o   <= 1'b0;
        end else begin
            phi_cnt   <= phi_cnt_nx;
            a2_phi1_o <= phi1_nx;
            if (m7_cnt == M7_LAST) begin
                m7_cnt  <= '0;
                a2_7M_o <= ~a2_7M_o;
            end else begin
                m7_cnt <= m7_cnt + 1'b1;
            end
        end
    end

    logic [15:0]   addr_mem [FIFO_DEPTH];
    logic [7:0]    data_mem [FIFO_DEPTH];
    logic          rw_mem   [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nx;
    logic          push_en, pop_en;

    always_comb begin
        push_en  = cyc_valid_i && cyc_ready_o && ((count != FIFO_FULL) || pop_evt);
        pop_en   = pop_evt && (count != '0);
        count_nx = count;
        if (push_en && !pop_en) begin
            count_nx = count + 1'b1;
        end else if (!push_en && pop_en) begin
            count_nx = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            addr_mem[wr_ptr] <= cyc_addr_i;
            data_mem[wr_ptr] <= cyc_data_i;
            rw_mem[wr_ptr]   <= cyc_rw_n_i;
        end
    end

    logic [15:0] cur_addr, cur_addr_nx;
    logic [7:0]  cur_data, cur_data_nx;
    logic        cur_rw_n, cur_rw_n_nx, cur_idle, cur_idle_nx;

    always_comb begin
        cur_addr_nx = cur_addr;
        cur_data_nx = cur_data;
        cur_rw_n_nx = cur_rw_n;
        cur_idle_nx = cur_idle;
        if (pop_evt) begin
            if (pop_en) begin
                cur_addr_nx = addr_mem[rd_ptr];
                cur_data_nx = data_mem[rd_ptr];
                cur_rw_n_nx = rw_mem[rd_ptr];
                cur_idle_nx = 1'b0;
            end else begin
                cur_addr_nx = 16'hFFFF;
                cur_data_nx = 8'hFF;
                cur_rw_n_nx = 1'b1;
                cur_idle_nx = 1'b1;
            end
        end
    end

    logic       wr_n_q, conflict, drive_nx, capture;
    logic [7:0] drive_byte;

    // Responses use the post-pop cycle and phase so a strobe on a pop edge sees the new cycle
    always_comb begin
        conflict   = !bridge_rd_n_i && !bridge_wr_n_i;
        drive_nx   = 1'b0;
        drive_byte = 8'hFF;
        if (!bridge_rd_n_i && bridge_wr_n_i) begin
            drive_nx = 1'b1;
            case (bridge_sel_i)
                3'd0: drive_byte = cur_addr_nx[7:0];
                3'd1: drive_byte = cur_addr_nx[15:8];
                3'd2: begin
                    if (!cur_rw_n_nx && phi0_nx) begin
                        drive_byte = cur_data_nx;
                    end else begin
                        drive_nx = 1'b0;
                    end
                end
                3'd3:    drive_byte = {cur_rw_n_nx, phi1_nx, 6'b0};
                default: drive_byte = 8'hFF;
            endcase
        end
        capture = !bridge_wr_n_i && bridge_rd_n_i && wr_n_q && (bridge_sel_i == 3'd2)
                  && cur_rw_n_nx && phi0_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            cyc_ready_o       <= 1'b1;
            idle_o            <= 1'b1;
            cur_addr          <= 16'hFFFF;
            cur_data          <= 8'hFF;
            cur_rw_n          <= 1'b1;
            cur_idle          <= 1'b1;
            bridge_d_o        <= 8'hFF;
            bridge_d_oe_o     <= 1'b0;
            card_data_o       <= 8'h00;
            card_data_valid_o <= 1'b0;
            error_o           <= 1'b0;
            wr_n_q            <= 1'b1;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count             <= count_nx;
            cyc_ready_o       <= (count_nx != FIFO_FULL) || pop_soon;
            idle_o            <= (count_nx == '0) && cur_idle_nx;
            cur_addr          <= cur_addr_nx;
            cur_data          <= cur_data_nx;
            cur_rw_n          <= cur_rw_n_nx;
            cur_idle          <= cur_idle_nx;
            bridge_d_oe_o     <= drive_nx;
            if (drive_nx) begin
                bridge_d_o <= drive_byte;
            end
            card_data_valid_o <= capture;
            if (capture) begin
                card_data_o <= bridge_d_i;
            end
            if (conflict) begin
                error_o <= 1'b1;
            end
            wr_n_q <= bridge_wr_n_i;
        end
    end
endmodule

// File: tb/tb_a2_bridge_responder.sv
// tb/tb_a2_bridge_responder.sv - randomized self-checking bench for a2_bridge_responder
module tb_a2_bridge_responder;
    localparam int HALF   = 27;
    localparam int PERIOD = 2 * HALF;
    localparam int M7     = 4;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc_valid = 1'b0;
    logic        cyc_ready;
    logic [15:0] cyc_addr = 16'h0000;
    logic [7:0]  cyc_data = 8'h00;
    logic        cyc_rw_n = 1'b1;
    logic        a2_phi1, a2_7m;
    logic [2:0]  sel = 3'd0;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [7:0]  d_in = 8'h00;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  card_data;
    logic        card_valid;
    logic        idle;
    logic        err;

    int checks = 0;
    int passes = 0;

    a2_bridge_responder #(.PHI_HALF(HALF), .M7_HALF(M7), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cyc_valid_i(cyc_valid), .cyc_ready_o(cyc_ready),
        .cyc_addr_i(cyc_addr), .cyc_data_i(cyc_data), .cyc_rw_n_i(cyc_rw_n),
        .a2_phi1_o(a2_phi1), .a2_7M_o(a2_7m),
        .bridge_sel_i(sel), .bridge_rd_n_i(rd_n), .bridge_wr_n_i(wr_n),
        .bridge_d_i(d_in), .bridge_d_o(d_out), .bridge_d_oe_o(d_oe),
        .card_data_o(card_data), .card_data_valid_o(card_valid),
        .idle_o(idle), .error_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        logic        idle;
    } cyc_t;

    cyc_t       q[$];
    cyc_t       m_cur;
    int         n;
    logic       m_ready, m_idle, m_oe, m_valid, m_err, m_prev_wr;
    logic [7:0] m_d, m_card;

    function automatic logic m_phi1();
        return ((n / HALF) % 2) == 0;
    endfunction

    function automatic logic m_7m();
        return ((n / M7) % 2) == 1;
    endfunction

    task automatic model_reset();
        n = 0;
        q.delete();
        m_cur.a = 16'hFFFF; m_cur.d = 8'hFF; m_cur.rw = 1'b1; m_cur.idle = 1'b1;
        m_ready = 1'b1; m_idle = 1'b1; m_oe = 1'b0; m_d = 8'hFF;
        m_card = 8'h00; m_valid = 1'b0; m_err = 1'b0; m_prev_wr = 1'b1;
    endtask

    // Cycle-level behaviour: edge number n says where we are in the phi period
    task automatic model_step();
        cyc_t e;
        logic ph1, ph0, push;
        push = cyc_valid && m_ready;
        n = n + 1;
        if (n % PERIOD == 0) begin
            if (q.size() > 0) begin
                m_cur = q.pop_front();
            end else begin
                m_cur.a = 16'hFFFF; m_cur.d = 8'hFF; m_cur.rw = 1'b1; m_cur.idle = 1'b1;
            end
        end
        if (push) begin
            e.a = cyc_addr; e.d = cyc_data; e.rw = cyc_rw_n; e.idle = 1'b0;
            q.push_back(e);
        end
        ph1 = m_phi1();
        ph0 = !ph1;
        m_oe = 1'b0;
        if (!rd_n && !wr_n) begin
            m_err = 1'b1;
        end else if (!rd_n) begin
            m_oe = 1'b1;
            case (sel)
                3'd0: m_d = m_cur.a[7:0];
                3'd1: m_d = m_cur.a[15:8];
                3'd2: if (!m_cur.rw && ph0) m_d = m_cur.d; else m_oe = 1'b0;
                3'd3: m_d = {m_cur.rw, ph1, 6'b0};
                default: m_d = 8'hFF;
            endcase
        end
        m_valid = !wr_n && rd_n && m_prev_wr && (sel == 3'd2) && m_cur.rw && ph0;
        if (m_valid) m_card = d_in;
        m_prev_wr = wr_n;
        m_ready = (q.size() < DEPTH) || ((n + 1) % PERIOD == 0);
        m_idle = (q.size() == 0) && m_cur.idle;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_pop();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while ((n % PERIOD) != 0 && k < 2 * PERIOD);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a2_phi1 !== 1'b1) $display("FAIL reset_phi1 got %b want 1", a2_phi1); else passes++;
        checks++; if (a2_7m !== 1'b0) $display("FAIL reset_7m got %b want 0", a2_7m); else passes++;
        checks++; if (cyc_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cyc_ready); else passes++;
        checks++; if (d_out !== 8'hFF || d_oe !== 1'b0) $display("FAIL reset_bridge got %h/%b want ff/0", d_out, d_oe); else passes++;
        checks++; if (card_data !== 8'h00 || card_valid !== 1'b0) $display("FAIL reset_card got %h/%b want 00/0", card_data, card_valid); else passes++;
        checks++; if (err !== 1'b0 || idle !== 1'b1) $display("FAIL reset_err_idle got %b/%b want 0/1", err, idle); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clocks();
        int phi_rises, m7_rises;
        logic p_prev, m_prev;
        phi_rises = 0; m7_rises = 0;
        p_prev = a2_phi1; m_prev = a2_7m;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (a2_phi1 && !p_prev) phi_rises++;
            if (a2_7m && !m_prev) m7_rises++;
            p_prev = a2_phi1; m_prev = a2_7m;
            checks++; if (a2_phi1 !== m_phi1()) $display("FAIL clk_phi1 n=%0d got %b want %b", n, a2_phi1, m_phi1()); else passes++;
            checks++; if (a2_7m !== m_7m()) $display("FAIL clk_7m n=%0d got %b want %b", n, a2_7m, m_7m()); else passes++;
            checks++; if (idle !== 1'b1 || d_oe !== 1'b0) $display("FAIL clk_idle_oe n=%0d got %b/%b want 1/0", n, idle, d_oe); else passes++;
        end
        checks++; if (phi_rises !== 3) $display("FAIL clk_phi_rises got %0d want 3", phi_rises); else passes++;
        checks++; if (m7_rises !== 25) $display("FAIL clk_7m_rises got %0d want 25", m7_rises); else passes++;
    endtask

    task automatic test_read_response();
        logic [7:0] want [4];
        want[0] = 8'hA5; want[1] = 8'hC0; want[2] = 8'h3C; want[3] = 8'h00;
        wait_pop();
        cyc_valid = 1'b1; cyc_addr = 16'hC0A5; cyc_data = 8'h3C; cyc_rw_n = 1'b0;
        tick();
        cyc_valid = 1'b0;
        wait_pop();
        repeat (28) tick();
        for (int s = 0; s < 4; s++) begin
            rd_n = 1'b0; sel = 3'(s);
            tick();
            checks++; if (d_oe !== 1'b1 || d_out !== want[s]) $display("FAIL rd_sel%0d got %b/%h want 1/%h", s, d_oe, d_out, want[s]); else passes++;
            rd_n = 1'b1;
            tick();
            checks++; if (d_oe !== 1'b0 || d_out !== want[s]) $display("FAIL rd_release%0d got %b/%h want 0/%h", s, d_oe, d_out, want[s]); else passes++;
        end
    endtask

    task automatic test_capture();
        wait_pop();
        cyc_valid = 1'b1; cyc_addr = 16'hC0B0; cyc_data = 8'($urandom); cyc_rw_n = 1'b1;
        tick();
        cyc_valid = 1'b0;
        wait_pop();
        repeat (28) tick();
        wr_n = 1'b0; sel = 3'd2; d_in = 8'h5A;
        tick();
        checks++; if (card_valid !== 1'b1 || card_data !== 8'h5A) $display("FAIL cap_pulse got %b/%h want 1/5a", card_valid, card_data); else passes++;
        d_in = 8'h77;
        tick();
        checks++; if (card_valid !== 1'b0 || card_data !== 8'h5A) $display("FAIL cap_once got %b/%h want 0/5a", card_valid, card_data); else passes++;
        wr_n = 1'b1;
        tick();
        rd_n = 1'b0;
        tick();
        checks++; if (d_oe !== 1'b0) $display("FAIL cap_rd_sel2 got oe %b want 0", d_oe); else passes++;
        rd_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        cyc_t e [5];
        logic [7:0] lo, hi;
        for (int i = 0; i < 5; i++) begin
            e[i].a = 16'($urandom_range(0, 16'hFFFE)); e[i].d = 8'($urandom);
            e[i].rw = 1'($urandom); e[i].idle = 1'b0;
        end
        wait_pop();
        for (int i = 0; i < 5; i++) begin
            cyc_valid = 1'b1; cyc_addr = e[i].a; cyc_data = e[i].d; cyc_rw_n = e[i].rw;
            checks++; if (cyc_ready !== (i < 4)) $display("FAIL b2b_ready%0d got %b want %b", i, cyc_ready, (i < 4)); else passes++;
            tick();
        end
        cyc_valid = 1'b0;
        for (int p = 0; p < 5; p++) begin
            lo = (p < 4) ? e[p].a[7:0] : 8'hFF;
            hi = (p < 4) ? e[p].a[15:8] : 8'hFF;
            wait_pop();
            tick();
            rd_n = 1'b0; sel = 3'd0;
            tick();
            checks++; if (d_out !== lo) $display("FAIL b2b_lo%0d got %h want %h", p, d_out, lo); else passes++;
            sel = 3'd1;
            tick();
            checks++; if (d_out !== hi) $display("FAIL b2b_hi%0d got %h want %h", p, d_out, hi); else passes++;
            rd_n = 1'b1;
            tick();
            checks++; if (idle !== (p == 4)) $display("FAIL b2b_idle%0d got %b want %b", p, idle, (p == 4)); else passes++;
        end
    endtask

    task automatic test_full_push_at_rise();
        cyc_t f [6];
        int k;
        for (int i = 0; i < 6; i++) begin
            f[i].a = 16'($urandom_range(0, 16'hFFFE)); f[i].d = 8'($urandom);
            f[i].rw = 1'b1; f[i].idle = 1'b0;
        end
        wait_pop();
        for (int i = 0; i < 4; i++) begin
            cyc_valid = 1'b1; cyc_addr = f[i].a; cyc_data = f[i].d; cyc_rw_n = f[i].rw;
            tick();
        end
        cyc_valid = 1'b0;
        tick();
        checks++; if (cyc_ready !== 1'b0) $display("FAIL full_ready_low got %b want 0", cyc_ready); else passes++;
        k = 0;
        while (((n + 1) % PERIOD) != 0 && k < PERIOD) begin
            tick();
            k++;
        end
        checks++; if (cyc_ready !== 1'b1) $display("FAIL full_ready_at_rise got %b want 1", cyc_ready); else passes++;
        cyc_valid = 1'b1; cyc_addr = f[4].a; cyc_data = f[4].d; cyc_rw_n = f[4].rw;
        tick();
        cyc_valid = 1'b0;
        checks++; if (cyc_ready !== 1'b0) $display("FAIL full_after_swap got %b want 0", cyc_ready); else passes++;
        rd_n = 1'b0; sel = 3'd0;
        tick();
        checks++; if (d_out !== f[0].a[7:0]) $display("FAIL full_popped got %h want %h", d_out, f[0].a[7:0]); else passes++;
        rd_n = 1'b1;
        cyc_valid = 1'b1; cyc_addr = f[5].a; cyc_data = f[5].d;
        tick();
        cyc_valid = 1'b0;
        for (int p = 1; p < 6; p++) begin
            wait_pop();
            tick();
            rd_n = 1'b0; sel = 3'd1;
            tick();
            rd_n = 1'b1;
            checks++;
            if (d_out !== ((p < 5) ? f[p].a[15:8] : 8'hFF))
                $display("FAIL full_replay%0d got %h want %h", p, d_out, (p < 5) ? f[p].a[15:8] : 8'hFF);
            else passes++;
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 900; i++) begin
            cyc_valid = ($urandom_range(0, 2) == 0);
            cyc_addr = 16'($urandom); cyc_data = 8'($urandom); cyc_rw_n = 1'($urandom);
            r = $urandom_range(0, 9);
            rd_n = !(r < 2);
            wr_n = !(r >= 2 && r < 4);
            sel = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom);
            d_in = 8'($urandom);
            tick();
            checks++; if (a2_phi1 !== m_phi1() || a2_7m !== m_7m()) $display("FAIL rnd_clk n=%0d got %b%b want %b%b", n, a2_phi1, a2_7m, m_phi1(), m_7m()); else passes++;
            checks++; if (cyc_ready !== m_ready) $display("FAIL rnd_ready n=%0d got %b want %b", n, cyc_ready, m_ready); else passes++;
            checks++; if (idle !== m_idle) $display("FAIL rnd_idle n=%0d got %b want %b", n, idle, m_idle); else passes++;
            checks++; if (d_oe !== m_oe || d_out !== m_d) $display("FAIL rnd_bridge n=%0d got %b/%h want %b/%h", n, d_oe, d_out, m_oe, m_d); else passes++;
            checks++; if (card_valid !== m_valid || card_data !== m_card) $display("FAIL rnd_card n=%0d got %b/%h want %b/%h", n, card_valid, card_data, m_valid, m_card); else passes++;
            checks++; if (err !== m_err) $display("FAIL rnd_err n=%0d got %b want %b", n, err, m_err); else passes++;
        end
        cyc_valid = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        tick();
    endtask

    task automatic test_error_and_reset();
        wait_pop();
        repeat (30) tick();
        rd_n = 1'b0; wr_n = 1'b0; sel = 3'd2; d_in = 8'hAA;
        tick();
        checks++; if (err !== 1'b1 || d_oe !== 1'b0 || card_valid !== 1'b0) $display("FAIL err_set got %b/%b/%b want 1/0/0", err, d_oe, card_valid); else passes++;
        rd_n = 1'b1; wr_n = 1'b1;
        repeat (3) tick();
        checks++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else passes++;
        for (int i = 0; i < 2; i++) begin
            cyc_valid = 1'b1; cyc_addr = 16'($urandom_range(0, 16'hFFFE)); cyc_rw_n = 1'b0;
            tick();
        end
        cyc_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (a2_phi1 !== 1'b1 || a2_7m !== 1'b0) $display("FAIL rst_clk got %b%b want 10", a2_phi1, a2_7m); else passes++;
        checks++; if (err !== 1'b0 || idle !== 1'b1 || cyc_ready !== 1'b1) $display("FAIL rst_flags got %b/%b/%b want 0/1/1", err, idle, cyc_ready); else passes++;
        checks++; if (d_out !== 8'hFF || d_oe !== 1'b0 || card_data !== 8'h00) $display("FAIL rst_data got %h/%b/%h want ff/0/00", d_out, d_oe, card_data); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_pop();
        tick();
        rd_n = 1'b0; sel = 3'd0;
        tick();
        rd_n = 1'b1;
        checks++; if (d_out !== 8'hFF || idle !== 1'b1) $display("FAIL rst_fifo_empty got %h/%b want ff/1", d_out, idle); else passes++;
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_read_response();
        test_capture();
        test_back_to_back();
        test_full_push_at_rise();
        test_random();
        test_error_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
